// File: rtl/sd_slot_arbiter.sv
// sd_slot_arbiter: round-robin sharing of one HPS SD block slot between a floppy
// (requester 0) and an SD (requester 1) sector client, one 512-byte block at a time.
module sd_slot_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  rq_rd,
    input  logic [1:0]  rq_wr,
    input  logic [31:0] rq_lba0,
    input  logic [31:0] rq_lba1,
    input  logic [7:0]  rq_din0,
    input  logic [7:0]  rq_din1,
    output logic [1:0]  rq_grant,
    output logic [1:0]  rq_done,
    output logic [1:0]  rq_err,
    output logic [1:0]  rq_buff_wr,
    input  logic        img_mounted,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
    state_t state, nxt;
    logic [2:0] mnt_s;
    logic [23:0] cnt;
    logic [1:0] pend, sel_oh;
    logic last, mounted, ack_d, sel, ack_fall, timed_out;

    assign pend = rq_rd | rq_wr;
    assign sel = &pend ? ~last : pend[1];
    assign sel_oh = sel ? 2'b10 : 2'b01;
    assign ack_fall = ack_d & ~sd_ack;
    assign timed_out = (TIMEOUT != 24'd0) && (cnt == TIMEOUT - 24'd1);

    always_ff @(negedge CLK or negedge RESET_N)
        if (!RESET_N) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = (|pend && mounted) ? ISSUE : IDLE;
            ISSUE: nxt = sd_ack ? XFER : (timed_out ? DONE : ISSUE);
            XFER:  nxt = ack_fall ? DONE : XFER;
            DONE:  nxt = IDLE;
        endcase
    end

    // Registered outputs and bookkeeping; an unmounted slot answers in IDLE with an error.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rq_grant <= 2'b00;
            rq_done  <= 2'b00;
            rq_err   <= 2'b00;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            sd_lba   <= 32'd0;
            last     <= 1'b1;
            mounted  <= 1'b0;
            mnt_s    <= 3'b000;
            ack_d    <= 1'b0;
            cnt      <= 24'd0;
        end else begin
            mnt_s   <= {mnt_s[1:0], img_mounted};
            ack_d   <= sd_ack;
            rq_done <= 2'b00;
            rq_err  <= 2'b00;
            if (mnt_s[2] & ~mnt_s[1]) mounted <= 1'b1;
            case (state)
                IDLE: if (|pend) begin
                    last <= sel;
                    if (!mounted) begin
                        rq_done <= sel_oh;
                        rq_err  <= sel_oh;
                    end else begin
                        rq_grant <= sel_oh;
                        sd_lba   <= sel ? rq_lba1 : rq_lba0;
                        sd_rd    <= rq_rd[sel];
                        sd_wr    <= ~rq_rd[sel];
                        cnt      <= 24'd0;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 24'd1;
                    if (sd_ack || timed_out) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                    if (!sd_ack && timed_out) begin
                        rq_done <= rq_grant;
                        rq_err  <= rq_grant;
                    end
                end
                XFER: if (ack_fall) rq_done <= rq_grant;
                DONE: begin
                    rq_grant <= 2'b00;
                    cnt      <= 24'd0;
                end
            endcase
        end
    end

    always_comb begin
        rq_buff_wr  = {2{sd_buff_wr & sd_ack}} & rq_grant;
        sd_buff_din = (rq_grant == 2'b01) ? rq_din0 : ((rq_grant == 2'b10) ? rq_din1 : 8'h00);
    end
endmodule

// File: tb/tb_sd_slot_arbiter.sv
// tb_sd_slot_arbiter: directed and randomized checks of sd_slot_arbiter against a
// transaction-level model, with a simple HPS responder driving sd_ack/sd_buff_wr.
module tb_sd_slot_arbiter;
    localparam int TMO = 16;

    logic CLK = 0, RESET_N = 1;
    logic [1:0] rq_rd = 0, rq_wr = 0;
    logic [31:0] rq_lba0 = 0, rq_lba1 = 0;
    logic [7:0] rq_din0, rq_din1 = 8'hFF;
    logic img_mounted = 0, sd_ack = 0, sd_buff_wr = 0;
    logic [8:0] buff_addr = 0;
    logic [1:0] rq_grant, rq_done, rq_err, rq_buff_wr;
    logic [31:0] sd_lba;
    logic sd_rd, sd_wr;
    logic [7:0] sd_buff_din;

    assign rq_din0 = buff_addr[7:0];

    sd_slot_arbiter #(.TIMEOUT(24'd16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .rq_rd(rq_rd), .rq_wr(rq_wr),
        .rq_lba0(rq_lba0), .rq_lba1(rq_lba1), .rq_din0(rq_din0), .rq_din1(rq_din1),
        .rq_grant(rq_grant), .rq_done(rq_done), .rq_err(rq_err), .rq_buff_wr(rq_buff_wr),
        .img_mounted(img_mounted), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    always #5 CLK = ~CLK;

    // HPS responder knobs
    int hps_delay = 5, hps_bytes = 4;
    bit hps_ack_en = 1, hps_ok;

    initial begin
        forever begin
            @(posedge CLK);
            if (sd_rd || sd_wr) begin
                hps_ok = 1;
                for (int k = 0; k < hps_delay; k++) begin
                    @(posedge CLK);
                    if (!(sd_rd || sd_wr)) begin hps_ok = 0; break; end
                end
                if (hps_ok && hps_ack_en) begin
                    sd_ack = 1;
                    for (int b = 0; b < hps_bytes; b++) begin
                        @(posedge CLK); buff_addr = 9'(b); sd_buff_wr = 1;
                        @(posedge CLK); sd_buff_wr = 0;
                    end
                    @(posedge CLK); sd_ack = 0;
                end else begin
                    for (int k = 0; k < 200 && (sd_rd || sd_wr); k++) @(posedge CLK);
                end
            end
        end
    end

    // Transaction-level model: who owns the slot, how long it has waited, whether acked.
    int m_owner = -1, m_waited = 0, who;
    bit m_rd, m_acked, m_closing, m_mounted, m_last = 1, m_ack_prev, m_fall;
    bit hist[3];
    logic [1:0] exp_grant = 0, exp_done = 0, exp_err = 0, pend;
    logic exp_rd = 0, exp_wr = 0;
    logic [31:0] exp_lba = 0;

    always @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_owner = -1; m_waited = 0; m_acked = 0; m_closing = 0;
            m_mounted = 0; m_last = 1; m_ack_prev = 0; hist = '{default: 0};
            exp_grant = 0; exp_done = 0; exp_err = 0; exp_rd = 0; exp_wr = 0; exp_lba = 0;
        end else begin
            m_fall = hist[2] && !hist[1];
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = img_mounted;
            exp_done = 0; exp_err = 0;
            pend = rq_rd | rq_wr;
            if (m_closing) begin
                m_closing = 0; m_owner = -1; exp_grant = 0;
            end else if (m_owner < 0) begin
                if (pend != 0) begin
                    who = (pend == 2'b11) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
                    m_last = (who == 1);
                    if (!m_mounted) begin
                        exp_done = 2'(1 << who); exp_err = 2'(1 << who);
                    end else begin
                        m_owner = who; m_rd = rq_rd[who]; m_waited = 0; m_acked = 0;
                        exp_lba = who ? rq_lba1 : rq_lba0;
                        exp_grant = 2'(1 << who); exp_rd = m_rd; exp_wr = !m_rd;
                    end
                end
            end else if (!m_acked) begin
                m_waited++;
                if (sd_ack) begin
                    m_acked = 1; exp_rd = 0; exp_wr = 0;
                end else if (m_waited == TMO) begin
                    exp_rd = 0; exp_wr = 0; exp_done = exp_grant; exp_err = exp_grant; m_closing = 1;
                end
            end else if (m_ack_prev && !sd_ack) begin
                exp_done = exp_grant; m_closing = 1;
            end
            m_ack_prev = sd_ack;
            if (m_fall) m_mounted = 1;
        end
    end

    int checks = 0, errors = 0;
    bit auto_drop = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle, compare every output with the model, and let clients drop on done.
    task automatic tick();
        @(posedge CLK); #3;
        chk("grant", rq_grant, exp_grant);
        chk("done", rq_done, exp_done);
        chk("err", rq_err, exp_err);
        chk("sd_rd", sd_rd, exp_rd);
        chk("sd_wr", sd_wr, exp_wr);
        chk("sd_lba", sd_lba, exp_lba);
        chk("buff_wr", rq_buff_wr, {2{sd_buff_wr & sd_ack}} & exp_grant);
        chk("buff_din", sd_buff_din, exp_grant == 2'b01 ? rq_din0 : (exp_grant == 2'b10 ? rq_din1 : 8'h00));
        if (auto_drop)
            for (int i = 0; i < 2; i++) if (rq_done[i]) begin rq_rd[i] = 0; rq_wr[i] = 0; end
    endtask

    task automatic do_reset();
        RESET_N = 0; rq_rd = 0; rq_wr = 0;
        tick(); tick();
        RESET_N = 1;
        tick();
    endtask

    task automatic mount();
        img_mounted = 1; tick(); tick();
        img_mounted = 0; repeat (5) tick();
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            tick();
            if (rq_grant == 0 && rq_rd == 0 && rq_wr == 0 && !sd_ack) break;
        end
        chk("idle_wait_expired", 32'(k >= 600), 0);
    endtask

    logic [1:0] dseen, eseen, order[3], first_strobe, prevg, last_done, last_err;
    int n0, n1, bad, ffs, nwr, ng, k;
    bit sseen;

    initial begin
        #2 RESET_N = 0;
        tick(); tick();
        chk("rst_grant", rq_grant, 2'b00);
        chk("rst_lba", sd_lba, 0);
        RESET_N = 1;
        tick();

        // unmounted slot rejects
        rq_rd = 2'b01; dseen = 0; eseen = 0; sseen = 0;
        repeat (4) begin tick(); dseen |= rq_done; eseen |= rq_err; sseen |= sd_rd | sd_wr; end
        chk("t1_done", dseen, 2'b01);
        chk("t1_err", eseen, 2'b01);
        chk("t1_no_strobe", sseen, 0);

        // 512-byte read on requester 1
        mount();
        hps_delay = 5; hps_bytes = 512; rq_lba1 = 32'h123; rq_rd = 2'b10;
        tick();
        chk("t2_lba", sd_lba, 32'h123);
        chk("t2_rd", sd_rd, 1);
        n0 = 0; n1 = 0; last_done = 0; last_err = 0;
        for (k = 0; k < 3000; k++) begin
            tick();
            n0 += rq_buff_wr[0]; n1 += rq_buff_wr[1];
            if (rq_done != 0) begin last_done = rq_done; last_err = rq_err; break; end
        end
        chk("t2_done", last_done, 2'b10);
        chk("t2_err", last_err, 2'b00);
        chk("t2_bytes1", n1, 512);
        chk("t2_bytes0", n0, 0);
        wait_idle();

        // both requesters, both rd and wr, held: 0,1,0 alternation with read winning
        do_reset(); mount();
        auto_drop = 0; hps_delay = 2; hps_bytes = 2;
        rq_rd = 2'b11; rq_wr = 2'b11; ng = 0; prevg = 0; first_strobe = 0;
        for (k = 0; k < 300 && ng < 3; k++) begin
            tick();
            if (rq_grant != 0 && prevg == 0) begin
                order[ng] = rq_grant;
                if (ng == 0) first_strobe = {sd_rd, sd_wr};
                ng++;
            end
            prevg = rq_grant;
        end
        chk("t3_grants", ng, 3);
        chk("t3_order0", order[0], 2'b01);
        chk("t3_order1", order[1], 2'b10);
        chk("t3_order2", order[2], 2'b01);
        chk("t3_read_wins", first_strobe, 2'b10);
        rq_rd = 0; rq_wr = 0; auto_drop = 1;
        wait_idle();

        // write on requester 0: only its data reaches the HPS
        rq_din1 = 8'hFF; hps_delay = 1; hps_bytes = 20; rq_lba0 = $urandom; rq_wr = 2'b01;
        bad = 0; ffs = 0; last_done = 0;
        for (k = 0; k < 300; k++) begin
            tick();
            if (rq_grant == 2'b01 && sd_ack && sd_buff_din !== buff_addr[7:0]) bad++;
            if (sd_buff_din == 8'hFF) ffs++;
            if (rq_done != 0) begin last_done = rq_done; break; end
        end
        chk("t4_din_bad", bad, 0);
        chk("t4_din1_seen", ffs, 0);
        chk("t4_done", last_done, 2'b01);
        wait_idle();

        // HPS never acks: 16-cycle strobe then error
        hps_ack_en = 0; rq_wr = 2'b01; nwr = 0; last_done = 0; last_err = 0;
        for (k = 0; k < 100; k++) begin
            tick();
            nwr += sd_wr;
            if (rq_done != 0) begin last_done = rq_done; last_err = rq_err; break; end
        end
        chk("t5_wr_cycles", nwr, 16);
        chk("t5_done", last_done, 2'b01);
        chk("t5_err", last_err, 2'b01);
        tick();
        chk("t5_grant_idle", rq_grant, 2'b00);
        hps_ack_en = 1;
        wait_idle();

        // reset during XFER, then the mount is gone
        hps_delay = 2; hps_bytes = 100; rq_rd = 2'b01;
        for (k = 0; k < 50 && !(sd_ack && rq_grant == 2'b01); k++) tick();
        repeat (3) tick();
        chk("t6_in_xfer", rq_grant, 2'b01);
        RESET_N = 0; rq_rd = 0;
        #1;
        chk("t6_grant", rq_grant, 2'b00);
        chk("t6_rd", sd_rd, 0);
        chk("t6_lba", sd_lba, 0);
        for (k = 0; k < 400 && sd_ack; k++) tick();
        RESET_N = 1;
        tick();
        rq_rd = 2'b01; dseen = 0; eseen = 0;
        repeat (4) begin tick(); dseen |= rq_done; eseen |= rq_err; end
        chk("t6_done", dseen, 2'b01);
        chk("t6_err", eseen, 2'b01);

        // randomized traffic
        mount();
        for (int t = 0; t < 60; t++) begin
            rq_din1 = 8'($urandom);
            hps_delay = $urandom_range(0, 18);
            hps_bytes = $urandom_range(1, 5);
            hps_ack_en = ($urandom % 8) != 0;
            pend = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) if (pend[i]) begin
                rq_rd[i] = $urandom % 2;
                rq_wr[i] = $urandom % 2;
                if (!rq_rd[i] && !rq_wr[i]) rq_rd[i] = 1;
            end
            for (k = 0; k < 600; k++) begin
                rq_lba0 = $urandom; rq_lba1 = $urandom;
                img_mounted = ($urandom % 16) == 0;
                tick();
                if (rq_grant == 0 && rq_rd == 0 && rq_wr == 0 && !sd_ack) break;
            end
            chk("rand_idle_expired", 32'(k >= 600), 0);
        end
        img_mounted = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_slot_arbiter.md
Name: sd_slot_arbiter

Overview:
- Shares one MiSTer SD block-level slot (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between two sector clients: requester 0 is the floppy controller, requester 1 is the SD controller.
- Serialises whole 512-byte block transactions with round-robin arbitration.
- Routes the byte-level buffer strobes and data to the granted client only.
- Rejects requests when no image is mounted, and times out requests the HPS never acknowledges.

Parameters:
- TIMEOUT, 24'd5_000_000, CLK cycles to wait in ISSUE for sd_ack rising before aborting. Width 24 bits; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all registers update on the falling edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- rq_rd  in  2  per-requester block-read request, level, held until rq_done.
- rq_wr  in  2  per-requester block-write request, level, held until rq_done.
- rq_lba0  in  32  LBA for requester 0.
- rq_lba1  in  32  LBA for requester 1.
- rq_din0  in  8  requester 0 write-buffer byte, for the current sd_buff_addr.
- rq_din1  in  8  requester 1 write-buffer byte, for the current sd_buff_addr.
- rq_grant  out  2  one-hot grant; 00 when idle.
- rq_done  out  2  one-cycle completion pulse per requester.
- rq_err  out  2  one-cycle error flag, coincident with rq_done.
- rq_buff_wr  out  2  gated sd_buff_wr per requester.
- img_mounted  in  1  mount strobe for this slot.
- sd_lba  out  32  to HPS.
- sd_rd  out  1  to HPS.
- sd_wr  out  1  to HPS.
- sd_ack  in  1  from HPS.
- sd_buff_wr  in  1  from HPS.
- sd_buff_din  out  8  to HPS.

Behaviour:

Reset values:
- rq_grant=00, rq_done=00, rq_err=00, sd_rd=0, sd_wr=0, sd_lba=0.
- FSM=IDLE, last=1 (so requester 0 wins first), mounted=0, timeout counter=0.

Mount flag:
- mounted is set on the falling edge of img_mounted (synchronised, edge detected on CLK).
- mounted is never cleared except by reset.
- A remount during a transfer does not affect the FSM.

Arbitration (IDLE only):
- A requester is pending when rq_rd[i] | rq_wr[i].
- If only one is pending, grant it.
- If both are pending, grant ~last.
- The grant is registered; last <= granted index.
- If rq_rd and rq_wr are both set on the granted requester, the read wins.

FSM states and transitions:
- IDLE:
  - If a request is pending and mounted=0: pulse rq_done[i] and rq_err[i] next cycle, no HPS activity, update last, stay IDLE.
  - Otherwise: latch the LBA into sd_lba, set the grant bit, go ISSUE.
- ISSUE:
  - Assert sd_rd or sd_wr (exactly one) and hold it.
  - Counter increments each cycle.
  - On sd_ack=1: drop sd_rd/sd_wr, go XFER.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 without ack: drop the strobe, go DONE with err=1.
- XFER:
  - Wait for the sd_ack falling edge (registered ack_d & ~sd_ack), then go DONE.
  - No timeout in XFER.
- DONE:
  - rq_done[g]=1 and rq_err[g]=err for exactly one cycle.
  - rq_grant <= 00, err cleared, counter cleared, go IDLE.
- Latency: first sd_rd/sd_wr is asserted 1 cycle after the request is seen in IDLE; rq_done pulses 1 cycle after the ack falling edge.
- A requester that deasserts its request mid-transaction does not abort it; rq_done still pulses.
- A request held after rq_done is treated as a new request. Round-robin then favours the other requester if it is pending.
- sd_lba is stable from ISSUE through DONE; LBA input changes after the grant are ignored.

Buffer routing (combinational):
- rq_buff_wr[i] = sd_buff_wr & sd_ack & rq_grant[i].
- sd_buff_din = rq_din0 when rq_grant=01, rq_din1 when rq_grant=10, else 8'h00.
- sd_buff_wr while no grant, or while sd_ack=0, reaches no client.

Reset mid-operation:
- Everything returns to reset values immediately, including the sd_rd/sd_wr drop.
- mounted is cleared, so a fresh img_mounted strobe is required.

Test Plan:
1. No mount; rq_rd=01 → within 2 cycles rq_done=01, rq_err=01; sd_rd never asserts.
2. Mount; rq_rd[1]=1, rq_lba1=0x123 → sd_lba=0x123 and sd_rd=1 one cycle later. HPS acks after 5 cycles, writes 512 bytes → rq_buff_wr[1] pulses 512 times, rq_buff_wr[0] never. rq_done=10 one cycle after ack falls.
3. rq_rd and rq_wr on both requesters, same cycle, after reset → requester 0 is served first with sd_rd (read wins). With both still requesting, requester 1 is served next, then requester 0 again (alternation over 3 transactions).
4. Write on requester 0, rq_din0 = sd_buff_addr[7:0] → sd_buff_din matches during ack; rq_din1=0xFF is never visible.
5. TIMEOUT=16, HPS never acks → sd_wr is high for exactly 16 cycles, then drops; rq_done/rq_err pulse together; FSM is back in IDLE.
6. RESET_N low during XFER → rq_grant=00 and sd_rd=0 immediately. After release, a request without a new mount returns rq_err.
